// File: rtl/relu_bwd_mac.sv
// Backward ReLU neuron: accumulates N rounded Q16.16 grad*weight products and gates the sum with the forward-pass derivative.
// Optional macro RELU_BWD_SAT_EN makes the product rounding and every accumulation saturate instead of wrapping.
module relu_bwd_mac #(
  parameter int N    = 4,
  parameter int FRAC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        d_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] grad,
  input  logic [31:0] weight,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_grad,
  output logic        busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [31:0] SMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t          state;
  state_t          next_state;
  logic [31:0]     acc;
  logic [CW-1:0]   count;
  logic            d_cap;
  logic [63:0]     prod;
  logic [31:0]     q;
  logic [31:0]     sum;
  logic            beat;
  logic            out_fire;

  assign beat     = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign prod = $signed({{32{grad[31]}}, grad}) * $signed({{32{weight[31]}}, weight});

`ifdef RELU_BWD_SAT_EN
  // Rounding can still overflow when the truncated product is already the maximum.
  logic [32:0] rnd;
  logic        unused_frac;
  assign rnd = {prod[FRAC+31], prod[FRAC+31:FRAC]} + {32'b0, prod[FRAC-1]};
  assign unused_frac = ^prod[FRAC-2:0];

  always_comb begin
    q = rnd[31:0];
    if (prod[63:FRAC+31] != {(33-FRAC){prod[63]}})
      q = prod[63] ? SMIN : SMAX;
    else if (rnd[32] != rnd[31])
      q = SMAX;
  end

  always_comb begin
    sum = acc + q;
    if ((acc[31] == q[31]) && (sum[31] != acc[31]))
      sum = acc[31] ? SMIN : SMAX;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{prod[63:FRAC+32], prod[FRAC-2:0]};
  assign q   = prod[FRAC+31:FRAC] + {31'b0, prod[FRAC-1]};
  assign sum = acc + q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACC;
      ACC:     if (beat && (count == LAST)) next_state = OUT;
      OUT:     if (out_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
  end

  // The result is registered on the edge accepting the last beat so out_valid and out_grad rise together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= 32'b0;
      count    <= '0;
      d_cap    <= 1'b0;
      out_grad <= 32'b0;
    end else begin
      if ((state == IDLE) && start) begin
        d_cap <= d_in;
        acc   <= 32'b0;
        count <= '0;
      end else if ((state == ACC) && beat) begin
        acc   <= sum;
        count <= count + CW'(1);
        if (count == LAST)
          out_grad <= d_cap ? sum : 32'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_bwd_mac.sv
// Directed, table-driven bench for relu_bwd_mac (N=4): sums, gating, rounding, stalls, backpressure, overflow, reset abort.
module tb_relu_bwd_mac;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        d_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] grad;
  logic [31:0] weight;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_grad;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct packed {
    logic            d;
    logic            gap;
    logic            pulse;
    logic [3:0]      hold;
    logic [3:0][31:0] g;
    logic [3:0][31:0] w;
    logic [31:0]     expv;
  } vec_t;

  vec_t vecs [6];

  relu_bwd_mac #(.N(4), .FRAC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d_in(d_in),
    .in_valid(in_valid), .in_ready(in_ready), .grad(grad), .weight(weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_grad(out_grad), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic d, input logic gap, input logic pulse, input logic [3:0] hold,
                              input logic [31:0] g0, g1, g2, g3,
                              input logic [31:0] w0, w1, w2, w3,
                              input logic [31:0] e);
    vec_t v;
    v.d = d; v.gap = gap; v.pulse = pulse; v.hold = hold;
    v.g[0] = g0; v.g[1] = g1; v.g[2] = g2; v.g[3] = g3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.expv = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act === expv)
      passCount++;
    else
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    start = 1'b1;
    d_in  = v.d;
    @(negedge clk);
    start = v.pulse;
    d_in  = ~v.d;
    checkOutput({tag, " busy after start"}, 32'(busy), 32'd1);
    checkOutput({tag, " in_ready in ACC"}, 32'(in_ready), 32'd1);
    for (int b = 0; b < 4; b++) begin
      if (v.gap) begin
        in_valid = 1'b0;
        grad     = 32'h1234_5678;
        weight   = 32'h0765_4321;
        @(negedge clk);
        checkOutput({tag, " stall out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " stall in_ready"}, 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1;
      grad     = v.g[b];
      weight   = v.w[b];
      @(negedge clk);
      checkOutput({tag, " out_valid timing"}, 32'(out_valid), (b == 3) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    checkOutput({tag, " out_grad"}, out_grad, v.expv);
    checkOutput({tag, " in_ready in OUT"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < int'(v.hold); h++) begin
      @(negedge clk);
      checkOutput({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " held out_grad"}, out_grad, v.expv);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " busy after handshake"}, 32'(busy), 32'd0);
    checkOutput({tag, " out_grad kept"}, out_grad, v.expv);
    @(negedge clk);
    checkOutput({tag, " idle in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; d_in = 1'b0;
    in_valid = 1'b0; grad = 32'b0; weight = 32'b0; out_ready = 1'b0;

    vecs[0] = mk(1'b1, 1'b0, 1'b0, 4'd0,
                 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000, 32'h0002_8000);
    vecs[1] = mk(1'b0, 1'b0, 1'b0, 4'd0,
                 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000);
    vecs[2] = mk(1'b1, 1'b1, 1'b0, 4'd3,
                 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_0004);
    vecs[3] = mk(1'b1, 1'b0, 1'b1, 4'd2,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000);
`ifdef RELU_BWD_SAT_EN
    vecs[4] = mk(1'b1, 1'b0, 1'b0, 4'd0,
                 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000,
                 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF);
`else
    vecs[4] = mk(1'b1, 1'b0, 1'b0, 4'd0,
                 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000,
                 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFE_0000);
`endif
    vecs[5] = mk(1'b1, 1'b1, 1'b1, 4'd1,
                 32'hFFFE_0000, 32'h0003_0000, 32'h0000_8000, 32'h0001_0000,
                 32'h0001_8000, 32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 32'h0001_4000);

    #12;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_grad", out_grad, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Abort after two beats; outputs must clear without waiting for a clock edge.
    @(negedge clk);
    start = 1'b1;
    d_in  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      grad     = 32'h0005_0000;
      weight   = 32'h0003_0000;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort out_grad", out_grad, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(vecs[0], "post-reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
